// File: rtl/sdram_arb_pkg.sv
// ==========================================================================
// sdram_arb_pkg : shared encodings and defaults for the SDRAM port arbiter
// Revision      : 1.0
// ==========================================================================
`default_nettype none

package sdram_arb_pkg;

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_READ    = 2'b10,
    OP_REFRESH = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_REQ  = 2'd2,
    ST_BUSY = 2'd3
  } state_e;

  localparam int unsigned FRAME_WORDS_DEF = 130560;
  localparam logic [23:0] BUF1_BASE_DEF   = 24'h40_0000;

  // Burst length clipped to the words left in the frame.
  function automatic logic [8:0] burst_words(input logic [17:0] remain,
                                             input logic [8:0]  blen);
    return (remain >= {9'd0, blen}) ? blen : remain[8:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_refresh_timer.sv
// ==========================================================================
// sdram_refresh_timer : periodic auto-refresh request with sticky overrun
// Revision            : 1.0
// ==========================================================================
`default_nettype none

module sdram_refresh_timer
  import sdram_arb_pkg::*;
#(
  parameter int unsigned REF_INTERVAL = 780
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic clr_i,
  output logic pending_o,
  output logic overrun_o
);

  localparam int unsigned     CW     = $clog2(REF_INTERVAL);
  localparam logic [CW-1:0]   C_LAST = CW'(REF_INTERVAL - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          ovr_q, ovr_d;
  logic          expire;

  assign expire = run_i && (cnt_q == C_LAST);

  always_comb begin
    cnt_d  = cnt_q;
    if (!run_i || expire) cnt_d = '0;
    else                  cnt_d = cnt_q + 1'b1;
    // A new interval always re-arms pending, even if the old one is acked now.
    pend_d = expire | (pend_q & ~clr_i);
    ovr_d  = ovr_q | (expire & pend_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  assign pending_o = pend_q;
  assign overrun_o = ovr_q;

endmodule

`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
// ==========================================================================
// sdram_port_arbiter : refresh/read/write scheduler with ping-pong buffers
// Revision           : 1.0
// ==========================================================================
`default_nettype none

module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned BURST_LEN    = 256,
  parameter int unsigned FRAME_WORDS  = FRAME_WORDS_DEF,
  parameter logic [23:0] BUF1_BASE    = BUF1_BASE_DEF,
  parameter int unsigned REF_INTERVAL = 780,
  parameter int unsigned RD_LOW       = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdram_init_done,
  input  logic        frame_valid,
  input  logic [9:0]  wr_usedw,
  input  logic [9:0]  rd_usedw,
  output logic        cmd_req,
  output logic [1:0]  cmd_op,
  output logic [23:0] cmd_addr,
  output logic [8:0]  cmd_len,
  input  logic        cmd_ack,
  input  logic        cmd_done,
  output logic        wr_buf,
  output logic        rd_buf,
  output logic        ref_overrun
);

  localparam logic [8:0]  C_BLEN   = 9'(BURST_LEN);
  localparam logic [17:0] C_FRAME  = 18'(FRAME_WORDS);
  localparam logic [9:0]  C_RD_LOW = 10'(RD_LOW);

  state_e      state_q, state_d;
  logic        cmd_req_q, cmd_req_d;
  cmd_op_e     op_q, op_d;
  logic [23:0] addr_q, addr_d;
  logic [8:0]  len_q, len_d;
  logic [17:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d;
  logic        last_done_q, last_done_d;
  logic        wr_armed_q, wr_armed_d;
  logic        restart_pend_q, restart_pend_d;
  logic [2:0]  fv_sync_q;

  logic        fv, fv_rise, ref_pending, ref_ack;
  logic [8:0]  wr_len, rd_len;
  logic [17:0] wr_next, rd_next;
  logic        rd_elig, wr_elig, xfer_done, wr_done, rd_done;
  logic        wr_inflight, wr_restart;

  assign fv      = fv_sync_q[1];
  assign fv_rise = fv_sync_q[1] & ~fv_sync_q[2];

  sdram_refresh_timer #(.REF_INTERVAL(REF_INTERVAL)) u_ref_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     (state_q != ST_INIT),
    .clr_i     (ref_ack),
    .pending_o (ref_pending),
    .overrun_o (ref_overrun)
  );

  assign ref_ack     = (state_q == ST_REQ) && cmd_ack && (op_q == OP_REFRESH);
  assign wr_len      = burst_words(C_FRAME - wr_ptr_q, C_BLEN);
  assign rd_len      = burst_words(C_FRAME - rd_ptr_q, C_BLEN);
  assign wr_next     = wr_ptr_q + 18'(len_q);
  assign rd_next     = rd_ptr_q + 18'(len_q);
  assign rd_elig     = rd_usedw < C_RD_LOW;
  assign wr_elig     = fv && wr_armed_q && (wr_usedw >= {1'b0, wr_len});
  // ack and done in the same cycle complete the command straight from REQ.
  assign xfer_done   = cmd_done && ((state_q == ST_BUSY) || ((state_q == ST_REQ) && cmd_ack));
  assign wr_done     = xfer_done && (op_q == OP_WRITE);
  assign rd_done     = xfer_done && (op_q == OP_READ);
  assign wr_inflight = ((state_q == ST_REQ) || (state_q == ST_BUSY)) && (op_q == OP_WRITE);
  assign wr_restart  = fv_rise | restart_pend_q;

  always_comb begin
    state_d   = state_q;
    cmd_req_d = cmd_req_q;
    op_d      = op_q;
    addr_d    = addr_q;
    len_d     = len_q;
    case (state_q)
      ST_INIT: if (sdram_init_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (ref_pending) begin
          op_d = OP_REFRESH; addr_d = '0; len_d = '0;
          cmd_req_d = 1'b1; state_d = ST_REQ;
        end else if (rd_elig) begin
          op_d = OP_READ; len_d = rd_len;
          addr_d = (rd_buf_q ? BUF1_BASE : 24'd0) + {6'd0, rd_ptr_q};
          cmd_req_d = 1'b1; state_d = ST_REQ;
        end else if (wr_elig) begin
          op_d = OP_WRITE; len_d = wr_len;
          addr_d = (wr_buf_q ? BUF1_BASE : 24'd0) + {6'd0, wr_ptr_q};
          cmd_req_d = 1'b1; state_d = ST_REQ;
        end
      end
      ST_REQ: if (cmd_ack) begin
        cmd_req_d = 1'b0;
        state_d   = cmd_done ? ST_IDLE : ST_BUSY;
      end
      ST_BUSY: if (cmd_done) state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    wr_buf_d       = wr_buf_q;
    rd_buf_d       = rd_buf_q;
    last_done_d    = last_done_q;
    wr_armed_d     = wr_armed_q;
    restart_pend_d = restart_pend_q;
    // A new camera frame restarts the write pointer, deferred to the end of any write in flight.
    if (wr_restart) begin
      if (!wr_inflight || wr_done) begin
        wr_ptr_d = '0; wr_armed_d = 1'b1; restart_pend_d = 1'b0;
      end else begin
        restart_pend_d = 1'b1;
      end
    end else if (wr_done) begin
      if (wr_next == C_FRAME) begin
        wr_ptr_d = '0; last_done_d = wr_buf_q; wr_buf_d = ~wr_buf_q; wr_armed_d = 1'b0;
      end else begin
        wr_ptr_d = wr_next;
      end
    end
    if (rd_done) begin
      if (rd_next == C_FRAME) begin
        rd_ptr_d = '0; rd_buf_d = last_done_q;
      end else begin
        rd_ptr_d = rd_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_INIT;
      cmd_req_q      <= 1'b0;
      op_q           <= OP_NONE;
      addr_q         <= '0;
      len_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      wr_buf_q       <= 1'b0;
      rd_buf_q       <= 1'b0;
      last_done_q    <= 1'b0;
      wr_armed_q     <= 1'b0;
      restart_pend_q <= 1'b0;
      fv_sync_q      <= '0;
    end else begin
      state_q        <= state_d;
      cmd_req_q      <= cmd_req_d;
      op_q           <= op_d;
      addr_q         <= addr_d;
      len_q          <= len_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_buf_q       <= wr_buf_d;
      rd_buf_q       <= rd_buf_d;
      last_done_q    <= last_done_d;
      wr_armed_q     <= wr_armed_d;
      restart_pend_q <= restart_pend_d;
      fv_sync_q      <= {fv_sync_q[1:0], frame_valid};
    end
  end

  assign cmd_req  = cmd_req_q;
  assign cmd_op   = op_q;
  assign cmd_addr = addr_q;
  assign cmd_len  = len_q;
  assign wr_buf   = wr_buf_q;
  assign rd_buf   = rd_buf_q;

endmodule

`default_nettype wire
